// File: rtl/dpll_pkg.sv
// -----------------------------------------------------------------------------
// dpll_pkg
// Shared definitions for the DPLL lock monitor:
//   - dpll_state_e : lock FSM states (encoding is visible on state_o)
//   - DEC_*        : 2-bit controller decision codes carried in status[1:0]
//   - STAT_STROBE  : bit index of the window-done strobe in status
//   - sat_inc16    : 16-bit increment that sticks at 16'hFFFF
// -----------------------------------------------------------------------------
package dpll_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        QUALIFY = 2'd1,
        LOCKED  = 2'd2,
        SLIP    = 2'd3
    } dpll_state_e;

    localparam logic [1:0] DEC_HOLD = 2'b00;
    localparam logic [1:0] DEC_UP   = 2'b01;
    localparam logic [1:0] DEC_DOWN = 2'b10;
    localparam logic [1:0] DEC_SAT  = 2'b11;

    localparam int STAT_STROBE = 2;

    // Run-length counters must never wrap back to a small value.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? 16'hFFFF : val + 16'd1;
    endfunction

endpackage

// File: rtl/dpll_win_classify.sv
// -----------------------------------------------------------------------------
// dpll_win_classify
// Classifies one controller decision window as good, bad or saturated, using
// the previous direction so that up/down dither between adjacent codes counts
// as in-lock. Holds the registered previous direction.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   strobe     : window-done strobe; prev_dir only advances on it
//   decision   : 2-bit controller decision
//   clr        : synchronous clear of prev_dir (wins over strobe)
//   good/bad/sat : combinational classification of the current decision
// -----------------------------------------------------------------------------
module dpll_win_classify
    import dpll_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe,
    input  logic [1:0] decision,
    input  logic       clr,
    output logic       good,
    output logic       bad,
    output logic       sat
);

    logic [1:0] prev_dir_q;
    logic [1:0] prev_dir_d;
    logic       is_dir;

    // A direction step is good only when it reverses the previous step;
    // a repeated step or a step out of a hold means the loop is walking.
    always_comb begin
        is_dir = (decision == DEC_UP) || (decision == DEC_DOWN);
        good   = (decision == DEC_HOLD) ||
                 (is_dir && (prev_dir_q != DEC_HOLD) && (decision != prev_dir_q));
        bad    = is_dir && ((prev_dir_q == DEC_HOLD) || (decision == prev_dir_q));
        sat    = (decision == DEC_SAT);
    end

    // prev_dir remembers the last step direction; hold and saturation forget it.
    always_comb begin
        prev_dir_d = prev_dir_q;
        if (clr) begin
            prev_dir_d = DEC_HOLD;
        end else if (strobe) begin
            prev_dir_d = is_dir ? decision : DEC_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_dir_q <= DEC_HOLD;
        end else begin
            prev_dir_q <= prev_dir_d;
        end
    end

endmodule

// File: rtl/dpll_lock_monitor.sv
// -----------------------------------------------------------------------------
// dpll_lock_monitor
// Qualifies the DPLL controller's per-window decisions into a debounced lock
// indication, a one-cycle lock-loss pulse and a sticky saturation error.
// Optional macro DPLL_LOCK_TIMEOUT_EN adds a sticky lock_timeout output driven
// by a window counter that runs while the loop is not locked.
// Ports:
//   ref_clk   : reference clock, rising edge
//   resetn    : asynchronous active-low reset
//   status    : [2] window-done strobe, [1:0] decision
//   clr       : synchronous clear (FSM to SEARCH, sat_err cleared)
//   locked    : qualified lock (LOCKED or SLIP)
//   lock_lost : one-cycle pulse when leaving LOCKED/SLIP for SEARCH
//   sat_err   : sticky saturated-decision flag
//   good_cnt  : current qualification / slip run length
//   state_o   : FSM state for debug
//   lock_timeout (DPLL_LOCK_TIMEOUT_EN only) : sticky lock budget exceeded
// -----------------------------------------------------------------------------
module dpll_lock_monitor
    import dpll_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
`ifdef DPLL_LOCK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_WINDOWS = 1024
`endif
)
(
    input  logic        ref_clk,
    input  logic        resetn,
    input  logic [2:0]  status,
    input  logic        clr,
    output logic        locked,
    output logic        lock_lost,
    output logic        sat_err,
    output logic [15:0] good_cnt,
    output logic [1:0]  state_o
`ifdef DPLL_LOCK_TIMEOUT_EN
    ,
    output logic        lock_timeout
`endif
);

    dpll_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        locked_q, locked_d;
    logic        lock_lost_q, lock_lost_d;
    logic        sat_err_q, sat_err_d;
    logic        strobe;
    logic        win_good, win_bad, win_sat;
    logic [15:0] cnt_next;

    assign strobe = status[STAT_STROBE];

    dpll_win_classify u_classify (
        .clk      (ref_clk),
        .rst_n    (resetn),
        .strobe   (strobe),
        .decision (status[1:0]),
        .clr      (clr),
        .good     (win_good),
        .bad      (win_bad),
        .sat      (win_sat)
    );

    // Next-state logic. clr beats everything, then saturation forces a
    // restart from any state; otherwise good/bad runs walk the lock FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sat_err_d   = sat_err_q;
        lock_lost_d = 1'b0;
        cnt_next    = sat_inc16(cnt_q);
        if (clr) begin
            state_d   = SEARCH;
            cnt_d     = 16'd0;
            sat_err_d = 1'b0;
        end else if (strobe) begin
            if (win_sat) begin
                state_d     = SEARCH;
                cnt_d       = 16'd0;
                sat_err_d   = 1'b1;
                lock_lost_d = (state_q == LOCKED) || (state_q == SLIP);
            end else begin
                unique case (state_q)
                    SEARCH: begin
                        if (win_good) begin
                            if (LOCK_COUNT == 1) begin
                                state_d = LOCKED;
                                cnt_d   = 16'd0;
                            end else begin
                                state_d = QUALIFY;
                                cnt_d   = 16'd1;
                            end
                        end else begin
                            cnt_d = 16'd0;
                        end
                    end
                    QUALIFY: begin
                        if (win_good) begin
                            if (cnt_next == 16'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                                cnt_d   = 16'd0;
                            end else begin
                                cnt_d = cnt_next;
                            end
                        end else if (win_bad) begin
                            state_d = SEARCH;
                            cnt_d   = 16'd0;
                        end
                    end
                    LOCKED: begin
                        if (win_bad) begin
                            if (UNLOCK_COUNT == 1) begin
                                state_d     = SEARCH;
                                cnt_d       = 16'd0;
                                lock_lost_d = 1'b1;
                            end else begin
                                state_d = SLIP;
                                cnt_d   = 16'd1;
                            end
                        end
                    end
                    SLIP: begin
                        if (win_good) begin
                            state_d = LOCKED;
                            cnt_d   = 16'd0;
                        end else if (win_bad) begin
                            if (cnt_next == 16'(UNLOCK_COUNT)) begin
                                state_d     = SEARCH;
                                cnt_d       = 16'd0;
                                lock_lost_d = 1'b1;
                            end else begin
                                cnt_d = cnt_next;
                            end
                        end
                    end
                    default: begin
                        state_d = SEARCH;
                        cnt_d   = 16'd0;
                    end
                endcase
            end
        end
        locked_d = (state_d == LOCKED) || (state_d == SLIP);
    end

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SEARCH;
            cnt_q       <= 16'd0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            sat_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            sat_err_q   <= sat_err_d;
        end
    end

    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
    assign sat_err   = sat_err_q;
    assign good_cnt  = cnt_q;
    assign state_o   = state_q;

`ifdef DPLL_LOCK_TIMEOUT_EN
    logic [15:0] win_cnt_q, win_cnt_d;
    logic        lock_timeout_q, lock_timeout_d;

    // Counts windows spent without lock; restarts when lock is achieved,
    // while the timeout flag itself survives until clr or reset.
    always_comb begin
        win_cnt_d      = win_cnt_q;
        lock_timeout_d = lock_timeout_q;
        if (clr) begin
            win_cnt_d      = 16'd0;
            lock_timeout_d = 1'b0;
        end else if (strobe && !locked_q) begin
            if (state_d == LOCKED) begin
                win_cnt_d = 16'd0;
            end else begin
                win_cnt_d = sat_inc16(win_cnt_q);
                if (win_cnt_d >= 16'(TIMEOUT_WINDOWS)) begin
                    lock_timeout_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt_q      <= 16'd0;
            lock_timeout_q <= 1'b0;
        end else begin
            win_cnt_q      <= win_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign lock_timeout = lock_timeout_q;
`endif

endmodule

// File: tb/tb_dpll_lock_monitor.sv
// -----------------------------------------------------------------------------
// tb_dpll_lock_monitor
// Directed testbench for dpll_lock_monitor (LOCK_COUNT=16, UNLOCK_COUNT=4,
// TIMEOUT_WINDOWS=8 when DPLL_LOCK_TIMEOUT_EN is defined).
// -----------------------------------------------------------------------------
module tb_dpll_lock_monitor;

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_QUALIFY = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [1:0] S_SLIP    = 2'd3;

    logic        ref_clk;
    logic        resetn;
    logic [2:0]  status;
    logic        clr;
    logic        locked;
    logic        lock_lost;
    logic        sat_err;
    logic [15:0] good_cnt;
    logic [1:0]  state_o;
`ifdef DPLL_LOCK_TIMEOUT_EN
    logic        lock_timeout;
`endif

    int compared   = 0;
    int mismatched = 0;

    dpll_lock_monitor #(
        .LOCK_COUNT   (16),
        .UNLOCK_COUNT (4)
`ifdef DPLL_LOCK_TIMEOUT_EN
        ,
        .TIMEOUT_WINDOWS (8)
`endif
    ) dut (
        .ref_clk   (ref_clk),
        .resetn    (resetn),
        .status    (status),
        .clr       (clr),
        .locked    (locked),
        .lock_lost (lock_lost),
        .sat_err   (sat_err),
        .good_cnt  (good_cnt),
        .state_o   (state_o)
`ifdef DPLL_LOCK_TIMEOUT_EN
        ,
        .lock_timeout (lock_timeout)
`endif
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] exp_state,
                               input logic [15:0] exp_cnt, input logic exp_locked,
                               input logic exp_lost, input logic exp_sat);
        checkOne({tag, ".state"},     {14'd0, state_o},   {14'd0, exp_state});
        checkOne({tag, ".good_cnt"},  good_cnt,           exp_cnt);
        checkOne({tag, ".locked"},    {15'd0, locked},    {15'd0, exp_locked});
        checkOne({tag, ".lock_lost"}, {15'd0, lock_lost}, {15'd0, exp_lost});
        checkOne({tag, ".sat_err"},   {15'd0, sat_err},   {15'd0, exp_sat});
    endtask

    // Drives one cycle of inputs starting 1 ns after a rising edge and
    // returns 1 ns after the following rising edge with inputs idle.
    task automatic applyStimulus(input logic stb, input logic [1:0] dec, input logic clr_in);
        status = {stb, dec};
        clr    = clr_in;
        @(posedge ref_clk);
        #1;
        status = 3'b000;
        clr    = 1'b0;
    endtask

    task automatic applyN(input int n, input logic [1:0] dec);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, dec, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        status = 3'b000;
        clr    = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        checkOutput("reset", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;

        // 16 holds: lock exactly after the 16th strobe
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("hold1", S_QUALIFY, 16'd1, 1'b0, 1'b0, 1'b0);
        applyN(14, 2'b00);
        checkOutput("hold15", S_QUALIFY, 16'd15, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkOutput("hold16", S_LOCKED, 16'd0, 1'b1, 1'b0, 1'b0);

        // no strobe: decision bits alone (even 11) must be ignored
        applyStimulus(1'b0, 2'b11, 1'b0);
        checkOutput("nostrobe", S_LOCKED, 16'd0, 1'b1, 1'b0, 1'b0);

        // four repeated up steps drop lock
        applyN(3, 2'b01);
        checkOutput("slip3", S_SLIP, 16'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("slip4", S_SEARCH, 16'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("slip4_after", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);

        // 15 holds then an up step out of hold: back to SEARCH
        applyN(15, 2'b00);
        checkOutput("q15", S_QUALIFY, 16'd15, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("q15_bad", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);

        // alternating dither: first 01 bad, then 16 good reversals
        applyStimulus(1'b0, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("alt1", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 16; i++) applyStimulus(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 1'b0);
        checkOutput("alt16", S_QUALIFY, 16'd15, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("alt17", S_LOCKED, 16'd0, 1'b1, 1'b0, 1'b0);

        // reversal while locked is dither and keeps lock
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkOutput("lk_dither", S_LOCKED, 16'd0, 1'b1, 1'b0, 1'b0);
        // repeated step enters SLIP, a reversal recovers
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkOutput("slip_in", S_SLIP, 16'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("slip_rec", S_LOCKED, 16'd0, 1'b1, 1'b0, 1'b0);

        // saturation while locked
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("sat", S_SEARCH, 16'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("sat_after", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b1);
        // clr beats a simultaneous good strobe
        applyStimulus(1'b1, 2'b00, 1'b1);
        checkOutput("clr_strobe", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);
        // clr beats a simultaneous saturated strobe
        applyStimulus(1'b1, 2'b11, 1'b1);
        checkOutput("clr_sat", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);
        // saturation from SEARCH sets sat_err with no lock_lost
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkOutput("sat_search", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-QUALIFY
        applyStimulus(1'b0, 2'b00, 1'b1);
        applyN(9, 2'b00);
        checkOutput("q9", S_QUALIFY, 16'd9, 1'b0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_rst", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge ref_clk);
        #1;
        resetn = 1'b1;
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("post_rst_bad", S_SEARCH, 16'd0, 1'b0, 1'b0, 1'b0);

`ifdef DPLL_LOCK_TIMEOUT_EN
        applyStimulus(1'b0, 2'b00, 1'b1);
        applyN(7, 2'b01);
        checkOne("tmo7", {15'd0, lock_timeout}, 16'd0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkOne("tmo8", {15'd0, lock_timeout}, 16'd1);
        applyN(16, 2'b00);
        checkOutput("tmo_lock", S_LOCKED, 16'd0, 1'b1, 1'b0, 1'b0);
        checkOne("tmo_sticky", {15'd0, lock_timeout}, 16'd1);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOne("tmo_clr", {15'd0, lock_timeout}, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
